// File: rtl/bram_arb_pkg.sv
// Shared constants and types for the two-master block RAM arbiter.
// Build option BRAM_ARB_RR_EN selects round-robin arbitration instead of m0 priority with starvation relief.
package bram_arb_pkg;

  localparam int CNT_WIDTH        = 4;
  localparam int DEF_STARVE_LIMIT = 4;

  // Requester ids, used as bit positions in the one-hot grant vector.
  localparam int REQ_M0 = 0;
  localparam int REQ_M1 = 1;

  // Encoding of the last_gnt register.
  localparam logic LAST_M0 = 1'b0;
  localparam logic LAST_M1 = 1'b1;

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_M0   = 2'd1,
    TAG_M2   = 2'd3,
    TAG_M1   = 2'd2
  } resp_tag_e;

endpackage

// File: rtl/bram_arb_pick.sv
// Combinational winner selector producing a one-hot grant for m0/m1.
// BRAM_ARB_RR_EN selects round-robin; otherwise m0 priority with a starvation override for m1.
module bram_arb_pick
  import bram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                 m0_req_i,
  input  logic                 m1_req_i,
  input  logic [CNT_WIDTH-1:0] starve_cnt_i,
  input  logic                 last_gnt_i,
  output logic [1:0]           gnt_o
);

  logic m1_pref;

`ifdef BRAM_ARB_RR_EN
  logic [CNT_WIDTH-1:0] unused_starve;
  assign unused_starve = starve_cnt_i;
  // Whoever did not win last time goes first on a tie.
  assign m1_pref = (last_gnt_i == LAST_M0);
`else
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);
  logic unused_last;
  assign unused_last = last_gnt_i;
  assign m1_pref = (starve_cnt_i == LIMIT);
`endif

  always_comb begin
    gnt_o = 2'b00;
    if (m0_req_i && m1_req_i) begin
      if (m1_pref) gnt_o[REQ_M1] = 1'b1;
      else         gnt_o[REQ_M0] = 1'b1;
    end else if (m0_req_i) begin
      gnt_o[REQ_M0] = 1'b1;
    end else if (m1_req_i) begin
      gnt_o[REQ_M1] = 1'b1;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one single-port byte-wide BRAM between m0 (core) and m1 (loader/debug), one access per cycle.
// Default build: m0 priority with STARVE_LIMIT relief for m1; BRAM_ARB_RR_EN builds strict round-robin.
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [7:0]            m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [7:0]            m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [7:0]            m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [7:0]            m1_rdata,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [7:0]            bram_wdata,
  output logic                  bram_wen,
  output logic                  bram_ren,
  input  logic [7:0]            bram_rdata
);

  // Handshake: a requester holds req/we/addr/wdata until it sees gnt=1 in the
  // same cycle; the access completes on the clk edge where req & gnt = 1.

  logic [1:0]           pick_gnt;
  logic [CNT_WIDTH-1:0] starve_cnt;
  logic                 last_gnt_q, last_gnt_d;
  resp_tag_e            resp_tag_q, resp_tag_d;

  bram_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .m0_req_i    (m0_req),
    .m1_req_i    (m1_req),
    .starve_cnt_i(starve_cnt),
    .last_gnt_i  (last_gnt_q),
    .gnt_o       (pick_gnt)
  );

  // Grants are suppressed while reset is asserted so nothing reaches the BRAM.
  assign m0_gnt = rst_n & pick_gnt[REQ_M0];
  assign m1_gnt = rst_n & pick_gnt[REQ_M1];

  assign bram_addr  = m1_gnt ? m1_addr  : m0_addr;
  assign bram_wdata = m1_gnt ? m1_wdata : m0_wdata;
  assign bram_wen   = (m0_gnt & m0_we)  | (m1_gnt & m1_we);
  assign bram_ren   = (m0_gnt & ~m0_we) | (m1_gnt & ~m1_we);

`ifdef BRAM_ARB_RR_EN
  assign starve_cnt = '0;
`else
  localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(STARVE_LIMIT);
  logic [CNT_WIDTH-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m1_req || m1_gnt) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q < LIMIT) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt = starve_cnt_q;
`endif

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (m0_gnt)      last_gnt_d = LAST_M0;
    else if (m1_gnt) last_gnt_d = LAST_M1;
  end

  // The tag remembers which master owns the data the BRAM returns next cycle.
  always_comb begin
    resp_tag_d = TAG_NONE;
    if (bram_ren) resp_tag_d = m1_gnt ? TAG_M1 : TAG_M0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt_q <= LAST_M1;
      resp_tag_q <= TAG_NONE;
    end else begin
      last_gnt_q <= last_gnt_d;
      resp_tag_q <= resp_tag_d;
    end
  end

  assign m0_rvalid = (resp_tag_q == TAG_M0);
  assign m1_rvalid = (resp_tag_q == TAG_M1);
  assign m0_rdata  = bram_rdata;
  assign m1_rdata  = bram_rdata;

endmodule
